// File: rtl/video_shifter.sv
// Character-mode video shifter: fetches screen code then glyph row over a req/ack bus,
// and shifts the pattern out MSB-first. Define VIDEO_SHIFTER_REVERSE_EN for reverse video.
module video_shifter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cclk_en_i,
  input  logic        pix_en_i,
  input  logic        h_sync_i,
  input  logic        v_sync_i,
  input  logic        de_i,
  input  logic [13:0] ma_i,
  input  logic [4:0]  ra_i,
  input  logic        graphic_i,
  output logic [16:0] bus_addr_o,
  output logic        bus_req_o,
  input  logic        bus_ack_i,
  input  logic [7:0]  bus_data_i,
  output logic        video_o,
  output logic        h_sync_o,
  output logic        v_sync_o,
  output logic        de_o,
  output logic        underrun_o
);

  localparam logic [16:0] VRAM_BASE = 17'h08000;
  localparam logic [16:0] CROM_BASE = 17'h10000;

  typedef enum logic [2:0] {IDLE, CODE, GLYPH, READY, DRAIN} state_t;

  state_t      state, state_d;
  logic        req_d;
  logic [16:0] addr_d;
  logic        launch;
  logic        pat_ld;
  logic [7:0]  pat_d;
  logic [7:0]  glyph_pat;

  // fetch stage (p0): sampled CRTC outputs and the pattern being assembled
  logic [10:0] ma_p0;
  logic [4:0]  ra_p0;
  logic        gr_p0;
  logic        de_p0;
  logic        hs_p0;
  logic        vs_p0;
  logic [7:0]  pat_p0;

  // output stage (p1)
  logic [7:0]  shift_reg;

  // newest sample: the one being latched this cycle, else the one already held
  logic [10:0] ma_n;
  logic [4:0]  ra_n;
  logic        de_n;
  logic        gr_n;
  logic        unused_ma_hi;

  assign ma_n = cclk_en_i ? ma_i[10:0] : ma_p0;
  assign ra_n = cclk_en_i ? ra_i       : ra_p0;
  assign de_n = cclk_en_i ? de_i       : de_p0;
  assign gr_n = cclk_en_i ? graphic_i  : gr_p0;
  assign unused_ma_hi = ^ma_i[13:11];

  function automatic logic [16:0] screen_addr(input logic [10:0] ma);
    return VRAM_BASE | {6'b0, ma};
  endfunction

  function automatic logic [16:0] glyph_addr(input logic gr, input logic [6:0] code,
                                             input logic [2:0] ra);
    return CROM_BASE | {6'b0, gr, code, ra};
  endfunction

  function automatic logic fetch_needed(input logic de, input logic [4:0] ra);
    return de && (ra[4:3] == 2'b00);
  endfunction

`ifdef VIDEO_SHIFTER_REVERSE_EN
  logic rev_p0;

  always_ff @(posedge clk_i) begin
    if (state == CODE && !cclk_en_i && bus_ack_i) rev_p0 <= bus_data_i[7];
  end

  assign glyph_pat = rev_p0 ? ~bus_data_i : bus_data_i;
`else
  assign glyph_pat = bus_data_i;
`endif

  always_comb begin
    state_d = state;
    req_d   = bus_req_o;
    addr_d  = bus_addr_o;
    launch  = 1'b0;
    pat_ld  = 1'b0;
    pat_d   = 8'h00;
    case (state)
      IDLE, READY: launch = cclk_en_i;
      CODE, GLYPH: begin
        if (cclk_en_i) begin
          // late: the request is still honoured, its data is thrown away in DRAIN
          state_d = DRAIN;
          if (bus_ack_i) req_d = 1'b0;
        end else if (bus_ack_i) begin
          if (state == CODE) begin
            state_d = GLYPH;
            addr_d  = glyph_addr(gr_p0, bus_data_i[6:0], ra_p0[2:0]);
          end else begin
            state_d = READY;
            req_d   = 1'b0;
            pat_ld  = 1'b1;
            pat_d   = glyph_pat;
          end
        end
      end
      DRAIN: begin
        if (bus_req_o) begin
          if (bus_ack_i) req_d = 1'b0;
        end else begin
          launch = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      if (fetch_needed(de_n, ra_n)) begin
        state_d = CODE;
        req_d   = 1'b1;
        addr_d  = screen_addr(ma_n);
      end else begin
        state_d = READY;
        req_d   = 1'b0;
        pat_ld  = 1'b1;
        pat_d   = 8'h00;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      bus_req_o  <= 1'b0;
      bus_addr_o <= 17'h0;
      underrun_o <= 1'b0;
      shift_reg  <= 8'h00;
      de_p0      <= 1'b0;
      hs_p0      <= 1'b0;
      vs_p0      <= 1'b0;
      de_o       <= 1'b0;
      h_sync_o   <= 1'b0;
      v_sync_o   <= 1'b0;
    end else begin
      state      <= state_d;
      bus_req_o  <= req_d;
      bus_addr_o <= addr_d;
      underrun_o <= cclk_en_i && (state == CODE || state == GLYPH || state == DRAIN);
      if (cclk_en_i) begin
        de_p0     <= de_i;
        hs_p0     <= h_sync_i;
        vs_p0     <= v_sync_i;
        de_o      <= de_p0;
        h_sync_o  <= hs_p0;
        v_sync_o  <= vs_p0;
        shift_reg <= (state == READY) ? pat_p0 : 8'h00;
      end else if (pix_en_i) begin
        shift_reg <= {shift_reg[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (cclk_en_i) begin
      ma_p0 <= ma_i[10:0];
      ra_p0 <= ra_i;
      gr_p0 <= graphic_i;
    end
    if (pat_ld) pat_p0 <= pat_d;
  end

  assign video_o = shift_reg[7] & de_o;

endmodule

// File: tb/tb_video_shifter.sv
// Directed bench for video_shifter: bus responder plus a per-character scoreboard
// of expected pixels, sync/DE and underrun, popped at each load edge.
`timescale 1ns/1ps
module tb_video_shifter;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cclk_en_i = 1'b0;
  logic        pix_en_i = 1'b0;
  logic        h_sync_i = 1'b0;
  logic        v_sync_i = 1'b0;
  logic        de_i = 1'b0;
  logic [13:0] ma_i = '0;
  logic [4:0]  ra_i = '0;
  logic        graphic_i = 1'b0;
  logic [16:0] bus_addr_o;
  logic        bus_req_o;
  logic        bus_ack_i = 1'b0;
  logic [7:0]  bus_data_i = '0;
  logic        video_o;
  logic        h_sync_o;
  logic        v_sync_o;
  logic        de_o;
  logic        underrun_o;

  always #5 clk = ~clk;

  video_shifter dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .cclk_en_i  (cclk_en_i),
    .pix_en_i   (pix_en_i),
    .h_sync_i   (h_sync_i),
    .v_sync_i   (v_sync_i),
    .de_i       (de_i),
    .ma_i       (ma_i),
    .ra_i       (ra_i),
    .graphic_i  (graphic_i),
    .bus_addr_o (bus_addr_o),
    .bus_req_o  (bus_req_o),
    .bus_ack_i  (bus_ack_i),
    .bus_data_i (bus_data_i),
    .video_o    (video_o),
    .h_sync_o   (h_sync_o),
    .v_sync_o   (v_sync_o),
    .de_o       (de_o),
    .underrun_o (underrun_o)
  );

  typedef struct packed {
    logic [7:0] pat;
    logic       de;
    logic       hs;
    logic       vs;
    logic       und;
  } exp_t;

  typedef struct packed {
    logic [16:0] a;
    logic        hold;
  } req_t;

  exp_t        expq[$];
  req_t        addrq[$];
  exp_t        cur = '0;
  int          checks = 0;
  int          errors = 0;
  int          phase = 0;
  int          pix_idx = 0;
  int          age = 0;
  int          ack_delay = 1;
  logic        last_cclk = 1'b0;
  logic        last_pix = 1'b0;
  logic        run = 1'b0;
  logic        fast_pix = 1'b0;
  logic [16:0] prev_addr = '0;
  logic [13:0] s_ma;
  logic [4:0]  s_ra;
  logic        s_de, s_gr, s_hs, s_vs, s_hold;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bench memory: a few fixed entries for the directed cases, a hash elsewhere.
  function automatic logic [7:0] mem(input logic [16:0] a);
    case (a)
      17'h08005: return 8'h01;
      17'h1000B: return 8'hA5;
      17'h08123: return 8'h81;
      17'h1040A: return 8'h0F;
      default:   return a[7:0] ^ a[15:8] ^ {a[16], 7'h35};
    endcase
  endfunction

  function automatic logic [16:0] scr_a(input logic [13:0] ma);
    return 17'h08000 | {6'b0, ma[10:0]};
  endfunction

  function automatic logic [16:0] gly_a(input logic gr, input logic [7:0] code, input logic [4:0] ra);
    return 17'h10000 | {6'b0, gr, code[6:0], ra[2:0]};
  endfunction

  function automatic logic [7:0] model_pat(input logic [13:0] ma, input logic [4:0] ra,
                                           input logic de, input logic gr);
    logic [7:0] code;
    logic [7:0] g;
    if (!de || ra >= 5'd8) return 8'h00;
    code = mem(scr_a(ma));
    g = mem(gly_a(gr, code, ra));
`ifdef VIDEO_SHIFTER_REVERSE_EN
    if (code[7]) g = ~g;
`endif
    return g;
  endfunction

  task automatic observe();
    logic exp_bit;
    if (last_cclk) begin
      check("scoreboard_depth", 17'(expq.size() != 0), 17'd1);
      if (expq.size() != 0) cur = expq.pop_front();
      pix_idx = 0;
      check("underrun_at_load", underrun_o, cur.und);
      check("de_o", de_o, cur.de);
      check("h_sync_o", h_sync_o, cur.hs);
      check("v_sync_o", v_sync_o, cur.vs);
      check("video_px0", video_o, cur.pat[7] & cur.de);
    end else if (last_pix) begin
      pix_idx++;
      exp_bit = (pix_idx < 8) ? cur.pat[3'(7 - pix_idx)] : 1'b0;
      check("video_px", video_o, exp_bit & cur.de);
      if (pix_idx == 1) check("underrun_single", underrun_o, 1'b0);
      if (pix_idx == 4) begin
        check("de_o_hold", de_o, cur.de);
        check("h_sync_o_hold", h_sync_o, cur.hs);
        check("v_sync_o_hold", v_sync_o, cur.vs);
      end
    end
  endtask

  task automatic drive(input bit do_rst, input bit force_ack);
    exp_t e;
    bit   ready;
    reset_i   = do_rst;
    cclk_en_i = run && !do_rst && (phase == 0);
    pix_en_i  = run && !do_rst && (fast_pix || (phase % 2 == 0));
    if (cclk_en_i) begin
      ma_i = s_ma; ra_i = s_ra; de_i = s_de; graphic_i = s_gr;
      h_sync_i = s_hs; v_sync_i = s_vs;
      e.de = s_de; e.hs = s_hs; e.vs = s_vs; e.und = s_hold;
      e.pat = s_hold ? 8'h00 : model_pat(s_ma, s_ra, s_de, s_gr);
      expq.push_back(e);
      if (s_de && s_ra < 5'd8) begin
        addrq.push_back({scr_a(s_ma), 1'b0});
        addrq.push_back({gly_a(s_gr, mem(scr_a(s_ma)), s_ra), s_hold});
      end
    end else begin
      ma_i = 14'($urandom); ra_i = 5'($urandom); de_i = 1'($urandom);
      graphic_i = 1'($urandom); h_sync_i = 1'($urandom); v_sync_i = 1'($urandom);
    end
    if (do_rst) begin
      expq.delete();
      expq.push_back('0);
      cur = '0;
      addrq.delete();
      age = 0;
    end
    bus_ack_i  = 1'b0;
    bus_data_i = 8'($urandom);
    if (force_ack) begin
      bus_ack_i = 1'b1;
    end else if (!do_rst) begin
      if (bus_req_o) begin
        if (age > 0) check("addr_stable", bus_addr_o, prev_addr);
        if (addrq.size() != 0 && addrq[0].hold && bus_addr_o[16]) ready = cclk_en_i;
        else ready = (age >= ack_delay);
        if (ready) begin
          bus_ack_i  = 1'b1;
          bus_data_i = mem(bus_addr_o);
          check("fetch_expected", 17'(addrq.size() != 0), 17'd1);
          if (addrq.size() != 0) check("fetch_addr", bus_addr_o, addrq.pop_front().a);
          age = 0;
        end else begin
          age++;
        end
        prev_addr = bus_addr_o;
      end else begin
        age = 0;
        if ($urandom_range(3) == 0) bus_ack_i = 1'b1;
      end
    end
    last_cclk = cclk_en_i;
    last_pix  = pix_en_i;
    phase     = (phase + 1) % 16;
  endtask

  task automatic period(input logic [13:0] ma, input logic [4:0] ra, input logic de,
                        input logic gr, input logic hs, input logic vs, input logic hold,
                        input logic fast, input int rst_at);
    s_ma = ma; s_ra = ra; s_de = de; s_gr = gr; s_hs = hs; s_vs = vs; s_hold = hold;
    fast_pix = fast;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      observe();
      if (rst_at >= 0 && k == rst_at) check("req_before_reset", bus_req_o, 1'b1);
      if (rst_at >= 0 && k == rst_at + 1) begin
        check("rst_req", bus_req_o, 1'b0);
        check("rst_video", video_o, 1'b0);
        check("rst_de", de_o, 1'b0);
        check("rst_hs", h_sync_o, 1'b0);
        check("rst_vs", v_sync_o, 1'b0);
        check("rst_underrun", underrun_o, 1'b0);
      end
      if (rst_at >= 0 && k == rst_at + 2) begin
        check("late_ack_req", bus_req_o, 1'b0);
        check("late_ack_addr", bus_addr_o, 17'h0);
      end
      drive(rst_at >= 0 && k == rst_at, rst_at >= 0 && k == rst_at + 1);
    end
    fast_pix = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    expq.push_back('0);
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_video", video_o, 1'b0);
    check("reset_hs", h_sync_o, 1'b0);
    check("reset_vs", v_sync_o, 1'b0);
    check("reset_de", de_o, 1'b0);
    check("reset_req", bus_req_o, 1'b0);
    check("reset_underrun", underrun_o, 1'b0);
    check("reset_addr", bus_addr_o, 17'h0);
    run = 1'b1;

    period(14'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    // basic fetch, then its pixels A5 during the next period
    period(14'h0005, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    period(14'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    // reverse-video code with ma high bits set; displayed with extra pixel enables
    period(14'h3923, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    period(14'h0777, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    // blank rows
    period(14'h0010, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    period(14'h0020, 5'h1F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    // underrun: glyph ack withheld until the next cclk_en, then a normal fetch from DRAIN
    period(14'h0040, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    period(14'h0041, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    // h_sync for three periods
    period(14'h0100, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    period(14'h0101, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    period(14'h0102, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    period(14'h0103, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      period(14'($urandom), 5'($urandom_range(0, 9)), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'b0, 1'b0, -1);
    end
    // reset while a slow fetch is outstanding, then a stray ack
    ack_delay = 6;
    period(14'h0200, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    ack_delay = 1;
    period(14'h0201, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    period(14'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    period(14'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
